// File: rtl/capp_tag_search.sv
// capp_tag_search
// Bit-serial masked-compare search stage of the CAPP array. One bit-slice of
// every cell word is compared against the latched comparand per clock, LSB
// first, and each cell's tag is cleared on the first cared-about mismatch.
// After the last slice a single COUNT cycle publishes popcount/any/valid and
// pulses done. CLEAR and SET_ALL skip the search and go straight to COUNT.
module capp_tag_search #(
    parameter  int WORD_W    = 32,
    parameter  int NUM_CELLS = 64,
    localparam int CNT_W     = $clog2(NUM_CELLS + 1)
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        start,
    input  logic [1:0]                  op,
    input  logic [WORD_W-1:0]           comparand,
    input  logic [WORD_W-1:0]           mask,
    input  logic [NUM_CELLS*WORD_W-1:0] cells_flat,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_CELLS-1:0]        tags,
    output logic                        tags_valid,
    output logic [CNT_W-1:0]            match_count,
    output logic                        match_any
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_COUNT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NEW     = 2'b00,
        OP_REFINE  = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_SET_ALL = 2'b11
    } op_t;

    // Control state
    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_bit_idx;

    // Operands latched at accept so the requester may move on
    logic [WORD_W-1:0]  r_comparand;
    logic [WORD_W-1:0]  r_mask;

    // Result registers
    logic [NUM_CELLS-1:0] r_tags;
    logic                 r_tags_valid;
    logic                 r_done;
    logic [CNT_W-1:0]     r_match_count;
    logic                 r_match_any;

    // Decoded per-cycle actions
    op_t                  w_op;
    logic                 w_accept;
    logic                 w_search_step;
    logic                 w_count_step;
    logic                 w_last_slice;

    // Datapath
    logic [NUM_CELLS-1:0] w_slice;
    logic                 w_comp_bit;
    logic                 w_mask_bit;
    logic [NUM_CELLS-1:0] w_tags_searched;
    logic [CNT_W-1:0]     w_popcount;

    assign w_op         = op_t'(op);
    assign w_last_slice = (r_bit_idx == IDX_W'(WORD_W - 1));

    // State register; an async reset mid-operation simply abandons it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of all the others.
            r_state <= w_state_next;
        end
    end

    // Next-state and action decode: accept only in IDLE, one COUNT cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_search_step = 1'b0;
        w_count_step  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_op == OP_NEW || w_op == OP_REFINE) begin
                        w_state_next = S_SEARCH;
                    end else begin
                        w_state_next = S_COUNT;
                    end
                end
            end
            S_SEARCH: begin
                w_search_step = 1'b1;
                if (w_last_slice) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                w_count_step = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Pick bit r_bit_idx out of every cell word: the current bit-slice.
    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        logic [WORD_W-1:0] w_word;
        assign w_word     = cells_flat[g*WORD_W +: WORD_W];
        assign w_slice[g] = w_word[r_bit_idx];
    end

    assign w_comp_bit = r_comparand[r_bit_idx];
    assign w_mask_bit = r_mask[r_bit_idx];

    // A cared-about slice knocks out every cell whose bit differs from the key;
    // a don't-care slice leaves all tags as they are.
    always_comb begin
        w_tags_searched = r_tags;
        if (w_mask_bit) begin
            w_tags_searched = r_tags & ~(w_slice ^ {NUM_CELLS{w_comp_bit}});
        end
    end

    // Population count of the settled tag vector, consumed in COUNT.
    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            w_popcount = w_popcount + CNT_W'(r_tags[i]);
        end
    end

    // Operand latch, slice pointer, tag vector and published results.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_comparand   <= '0;
            r_mask        <= '0;
            r_bit_idx     <= '0;
            r_tags        <= '0;
            r_tags_valid  <= 1'b0;
            r_done        <= 1'b0;
            r_match_count <= '0;
            r_match_any   <= 1'b0;
        end else begin
            r_done <= w_count_step;

            if (w_accept) begin
                r_comparand  <= comparand;
                r_mask       <= mask;
                r_bit_idx    <= '0;
                r_tags_valid <= 1'b0;
                unique case (w_op)
                    OP_NEW:     r_tags <= '1;
                    OP_REFINE:  r_tags <= r_tags;
                    OP_CLEAR:   r_tags <= '0;
                    OP_SET_ALL: r_tags <= '1;
                    default:    r_tags <= r_tags;
                endcase
            end

            if (w_search_step) begin
                r_tags    <= w_tags_searched;
                r_bit_idx <= w_last_slice ? '0 : r_bit_idx + IDX_W'(1);
            end

            if (w_count_step) begin
                r_match_count <= w_popcount;
                r_match_any   <= |r_tags;
                r_tags_valid  <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign tags        = r_tags;
    assign tags_valid  = r_tags_valid;
    assign match_count = r_match_count;
    assign match_any   = r_match_any;

endmodule
